smem_ext_bridge: RTL and testbench
==================================

# smem_ext_bridge

Pin-reduced external access bridge to the on-chip scratch SRAM. It replaces the wide parallel external SRAM pin set with a narrow, time-multiplexed nibble bus and a valid/ready handshake. Optional burst transfers auto-increment the address. It sits in the chip core between the input/output pad cells and the SRAM port arbiter, and drives the SRAM's external-access port.

## Interface
- ADDR_W, 12, SRAM word address width; must be a multiple of PIN_W
- DATA_W, 16, SRAM word width; must be a multiple of PIN_W
- PIN_W, 4, external bus width per beat; must be ≥ 2
- i_clk  in  1  core clock; all logic is rising-edge
- i_reset  in  1  asynchronous, active-high reset
- i_en  in  1  bridge enable (external-access mode strap); low forces idle
- i_ext_valid  in  1  external beat valid
- i_ext_data  in  PIN_W  external beat payload
- o_ext_ready  out  1  bridge can accept a beat this cycle
- o_ext_rvalid  out  1  read-data beat valid
- o_ext_rdata  out  PIN_W  read-data beat payload
- o_busy  out  1  a frame is in progress (state ≠ IDLE)
- o_smem_cen  out  1  SRAM chip enable, active-low
- o_smem_wen  out  1  SRAM write enable, active-low
- o_smem_addr  out  ADDR_W  SRAM address
- o_smem_wdata  out  DATA_W  SRAM write data
- i_smem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read access

## Operation
- A beat is accepted on a rising edge when i_ext_valid && o_ext_ready. Gaps in i_ext_valid between beats are allowed.
- o_ext_ready = i_en && state ∈ {IDLE, ADDR, WDATA}.
- The frame starts with a header beat:
  - bit0 = 1 selects write, 0 selects read.
  - bits[PIN_W-1:1] = burst length − 1 (1..2^(PIN_W-1) words).
- Next come ADDR_W/PIN_W address beats, least-significant slice first.
- Write frame: for each word, DATA_W/PIN_W data beats (LSB slice first), then a single SRAM write cycle.
- Read frame: for each word, an SRAM read, then DATA_W/PIN_W output beats (LSB slice first). The read output has no backpressure.
- Between words the address increments by 1, wrapping modulo 2^ADDR_W.
- State machine:
  - IDLE: on a header beat, latch direction and length → ADDR.
  - ADDR: shift in address; on the last beat → WDATA (write) or READ (read).
  - WDATA: shift in a word; on the last beat → WRITE.
  - WRITE: o_smem_cen=0, o_smem_wen=0 for exactly one cycle. Words remaining → address+1, WDATA; otherwise → IDLE.
  - READ: o_smem_cen=0, o_smem_wen=1 for exactly one cycle → RCAP.
  - RCAP: load i_smem_rdata into the output shift register → ROUT.
  - ROUT: o_ext_rvalid=1 and o_ext_rdata = low slice, shifting each cycle. After the last beat: words remaining → address+1, READ; otherwise → IDLE.
- In every state other than WRITE and READ: o_smem_cen=1, o_smem_wen=1.
- i_en low in any state returns to IDLE on the next edge, aborting the frame. No SRAM access is issued and partial data is discarded.
- The beat counter and word counter are cleared on every IDLE entry.

## Timing
- Reset values:
  - state IDLE
  - o_ext_rvalid=0, o_ext_rdata=0, o_busy=0
  - o_smem_cen=1, o_smem_wen=1, o_smem_addr=0, o_smem_wdata=0
  - o_ext_ready follows i_en
- Write latency: last data beat accepted at edge N → SRAM write cycle N+1 → o_ext_ready high again at N+2.
- Read latency: last address beat accepted at edge N → READ at N+1, RCAP at N+2 → first o_ext_rvalid at N+3. The stream is contiguous for DATA_W/PIN_W cycles.
- Burst read: the next word's first rvalid comes 3 cycles after the previous word's last rvalid.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronous). No SRAM access completes afterwards.
- i_en low and i_ext_valid high in the same cycle: the beat is not accepted, because ready is low.

## Configuration
- SMEM_BRIDGE_BURST_EN defined: header length bits are honoured and the word counter plus address incrementer are compiled in.
- SMEM_BRIDGE_BURST_EN undefined: length bits are ignored, every frame transfers exactly one word, and the word counter and incrementer are absent.

## Test plan
All scenarios use default parameters.
- Single write: header 4'h1; address beats 4'h4, 4'h3, 4'h2; data beats 4'hD, 4'hC, 4'hB, 4'hA → one cycle with cen=0, wen=0, addr=0x234, wdata=0xABCD; ready low for exactly that cycle.
- Single read: header 4'h0; address 0x234; SRAM model returns 0xABCD → rvalid begins 3 cycles after the last address beat, rdata D, C, B, A on 4 consecutive cycles.
- Burst write with wrap (BURST_EN defined): header 4'h5 at address 0xFFE, data 0x1111, 0x2222, 0x3333 → writes land at 0xFFE, 0xFFF, 0x000. Without the macro: only 0xFFE is written and the bridge returns to IDLE.
- Valid gaps: insert 3 idle cycles between every beat of the single-write frame → same SRAM write as the first scenario.
- Abort: drop i_en after the second address beat, then restore it and send the single-read frame → no SRAM access for the aborted frame; the read completes normally.
- Reset during ROUT on the 2nd beat → rvalid=0, cen=1, busy=0 immediately; the next frame works.

Source files
------------

// File: rtl/smem_ext_bridge_if.sv
// Nibble-bus handshake and SRAM external-access signals of smem_ext_bridge.
// Member names carry the direction prefix as seen from the bridge.
interface smem_ext_bridge_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int PIN_W  = 4
);
  logic              i_ext_valid;
  logic [PIN_W-1:0]  i_ext_data;
  logic              o_ext_ready;
  logic              o_ext_rvalid;
  logic [PIN_W-1:0]  o_ext_rdata;
  logic              o_busy;
  logic              o_smem_cen;
  logic              o_smem_wen;
  logic [ADDR_W-1:0] o_smem_addr;
  logic [DATA_W-1:0] o_smem_wdata;
  logic [DATA_W-1:0] i_smem_rdata;

  modport slave (
    input  i_ext_valid, i_ext_data, i_smem_rdata,
    output o_ext_ready, o_ext_rvalid, o_ext_rdata, o_busy,
           o_smem_cen, o_smem_wen, o_smem_addr, o_smem_wdata
  );

  modport master (
    output i_ext_valid, i_ext_data, i_smem_rdata,
    input  o_ext_ready, o_ext_rvalid, o_ext_rdata, o_busy,
           o_smem_cen, o_smem_wen, o_smem_addr, o_smem_wdata
  );
endinterface

// File: rtl/smem_ext_bridge.sv
// Pin-reduced nibble-bus bridge onto the scratch SRAM external-access port.
// Define SMEM_BRIDGE_BURST_EN to honour header burst lengths (auto-increment).
module smem_ext_bridge #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int PIN_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  smem_ext_bridge_if.slave  io_bus
);
  localparam int ADDR_BEATS = ADDR_W / PIN_W;
  localparam int DATA_BEATS = DATA_W / PIN_W;
  localparam int MAX_BEATS  = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
  localparam int BEAT_W     = $clog2(MAX_BEATS) + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4,
    ST_RCAP  = 3'd5,
    ST_ROUT  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic                r_wr;
  logic [BEAT_W-1:0]   r_beat;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rsh;
  logic                r_rvalid;
  logic                r_busy;
  logic                r_cen;
  logic                r_wen;
  logic                w_ready;
  logic                w_acc;
  logic                w_addr_last;
  logic                w_data_last;
  logic                w_more;

`ifdef SMEM_BRIDGE_BURST_EN
  logic [PIN_W-2:0]    r_len;
  logic [PIN_W-2:0]    r_wcnt;
  assign w_more = (r_wcnt != r_len);
`else
  assign w_more = 1'b0;
`endif

  assign w_ready     = i_en && (r_state == ST_IDLE || r_state == ST_ADDR || r_state == ST_WDATA);
  assign w_acc       = io_bus.i_ext_valid && w_ready;
  assign w_addr_last = (r_beat == BEAT_W'(ADDR_BEATS - 1));
  assign w_data_last = (r_beat == BEAT_W'(DATA_BEATS - 1));

  assign io_bus.o_ext_ready  = w_ready;
  assign io_bus.o_ext_rvalid = r_rvalid;
  assign io_bus.o_ext_rdata  = r_rsh[PIN_W-1:0];
  assign io_bus.o_busy       = r_busy;
  assign io_bus.o_smem_cen   = r_cen;
  assign io_bus.o_smem_wen   = r_wen;
  assign io_bus.o_smem_addr  = r_addr;
  assign io_bus.o_smem_wdata = r_wdata;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode; dropping i_en aborts any frame
  always_comb begin
    w_state_nx = r_state;
    if (!i_en) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_acc) w_state_nx = ST_ADDR; else w_state_nx = ST_IDLE;
        ST_ADDR:  if (w_acc && w_addr_last) w_state_nx = r_wr ? ST_WDATA : ST_READ;
                  else w_state_nx = ST_ADDR;
        ST_WDATA: if (w_acc && w_data_last) w_state_nx = ST_WRITE; else w_state_nx = ST_WDATA;
        ST_WRITE: if (w_more) w_state_nx = ST_WDATA; else w_state_nx = ST_IDLE;
        ST_READ:  w_state_nx = ST_RCAP;
        ST_RCAP:  w_state_nx = ST_ROUT;
        ST_ROUT:  if (w_data_last) w_state_nx = w_more ? ST_READ : ST_IDLE;
                  else w_state_nx = ST_ROUT;
        default:  w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs, decoded from the next state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr     <= 1'b0;
      r_beat   <= {BEAT_W{1'b0}};
      r_addr   <= {ADDR_W{1'b0}};
      r_wdata  <= {DATA_W{1'b0}};
      r_rsh    <= {DATA_W{1'b0}};
      r_rvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_cen    <= 1'b1;
      r_wen    <= 1'b1;
`ifdef SMEM_BRIDGE_BURST_EN
      r_len    <= {(PIN_W-1){1'b0}};
      r_wcnt   <= {(PIN_W-1){1'b0}};
`endif
    end else begin
      r_cen    <= !(w_state_nx == ST_WRITE || w_state_nx == ST_READ);
      r_wen    <= !(w_state_nx == ST_WRITE);
      r_rvalid <= (w_state_nx == ST_ROUT);
      r_busy   <= (w_state_nx != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_wr  <= io_bus.i_ext_data[0];
`ifdef SMEM_BRIDGE_BURST_EN
            r_len <= io_bus.i_ext_data[PIN_W-1:1];
`endif
          end
        end
        ST_ADDR: begin
          if (w_acc) begin
            r_addr <= {io_bus.i_ext_data, r_addr[ADDR_W-1:PIN_W]};
            r_beat <= w_addr_last ? {BEAT_W{1'b0}} : r_beat + BEAT_W'(1);
          end
        end
        ST_WDATA: begin
          if (w_acc) begin
            r_wdata <= {io_bus.i_ext_data, r_wdata[DATA_W-1:PIN_W]};
            r_beat  <= w_data_last ? {BEAT_W{1'b0}} : r_beat + BEAT_W'(1);
          end
        end
        ST_WRITE: begin
`ifdef SMEM_BRIDGE_BURST_EN
          if (w_more) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_wcnt <= r_wcnt + (PIN_W-1)'(1);
          end
`endif
        end
        ST_READ: begin
        end
        ST_RCAP: begin
          r_rsh <= io_bus.i_smem_rdata;
        end
        ST_ROUT: begin
          r_rsh  <= r_rsh >> PIN_W;
          r_beat <= w_data_last ? {BEAT_W{1'b0}} : r_beat + BEAT_W'(1);
`ifdef SMEM_BRIDGE_BURST_EN
          if (w_data_last && w_more) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_wcnt <= r_wcnt + (PIN_W-1)'(1);
          end
`endif
        end
        default: begin
        end
      endcase
      // Every return to idle discards partial progress
      if (w_state_nx == ST_IDLE) begin
        r_beat <= {BEAT_W{1'b0}};
        r_rsh  <= {DATA_W{1'b0}};
`ifdef SMEM_BRIDGE_BURST_EN
        r_wcnt <= {(PIN_W-1){1'b0}};
`endif
      end
    end
  end
endmodule

// File: tb/tb_smem_ext_bridge.sv
// Directed self-checking bench for smem_ext_bridge with a behavioural SRAM.
module tb_smem_ext_bridge;
  logic clk = 1'b0;
  logic rst;
  logic en;
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   snap;
  logic [15:0] mem [0:4095];

  smem_ext_bridge_if u_if ();

  smem_ext_bridge u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_en    (en),
    .io_bus  (u_if)
  );

  always #5 clk = ~clk;

  // SRAM model: read data appears one cycle after the access
  always @(posedge clk) begin
    if (u_if.o_smem_cen === 1'b0) begin
      if (u_if.o_smem_wen === 1'b0) mem[u_if.o_smem_addr] <= u_if.o_smem_wdata;
      else u_if.i_smem_rdata <= mem[u_if.o_smem_addr];
    end
  end

  always @(negedge clk) begin
    if (u_if.o_smem_cen === 1'b0) acc_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    u_if.i_ext_valid = 1'b1;
    u_if.i_ext_data  = d;
    n = 0;
    while (u_if.o_ext_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("beat_ready", u_if.o_ext_ready, 1);
    @(posedge clk);
    #1;
    u_if.i_ext_valid = 1'b0;
  endtask

  task automatic send_hdr_addr(input logic [3:0] hdr, input logic [11:0] a, input int gap);
    send(hdr, gap);
    for (int i = 0; i < 3; i++) send(a[4*i +: 4], gap);
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    for (int i = 0; i < 4; i++) send(w[4*i +: 4], gap);
  endtask

  task automatic expect_write(input logic [11:0] a, input logic [15:0] d, input logic busy_after);
    @(negedge clk);
    chk("wr_cen", u_if.o_smem_cen, 0);
    chk("wr_wen", u_if.o_smem_wen, 0);
    chk("wr_addr", u_if.o_smem_addr, a);
    chk("wr_data", u_if.o_smem_wdata, d);
    chk("wr_ready_low", u_if.o_ext_ready, 0);
    @(negedge clk);
    chk("wr_cen_after", u_if.o_smem_cen, 1);
    chk("wr_ready_after", u_if.o_ext_ready, 1);
    chk("wr_busy_after", u_if.o_busy, busy_after);
  endtask

  task automatic expect_read(input logic [15:0] d);
    @(negedge clk);
    chk("rd_cen", u_if.o_smem_cen, 0);
    chk("rd_wen", u_if.o_smem_wen, 1);
    chk("rd_rvalid_read", u_if.o_ext_rvalid, 0);
    @(negedge clk);
    chk("rd_rvalid_rcap", u_if.o_ext_rvalid, 0);
    chk("rd_cen_rcap", u_if.o_smem_cen, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rd_rvalid", u_if.o_ext_rvalid, 1);
      chk("rd_rdata", u_if.o_ext_rdata, d[4*i +: 4]);
    end
    @(negedge clk);
    chk("rd_rvalid_end", u_if.o_ext_rvalid, 0);
    chk("rd_busy_end", u_if.o_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    u_if.i_ext_valid = 1'b0;
    u_if.i_ext_data  = 4'h0;
    #12;
    chk("rst_ready_en_low", u_if.o_ext_ready, 0);
    en = 1'b1;
    #1;
    chk("rst_ready_en_high", u_if.o_ext_ready, 1);
    chk("rst_rvalid", u_if.o_ext_rvalid, 0);
    chk("rst_rdata", u_if.o_ext_rdata, 0);
    chk("rst_busy", u_if.o_busy, 0);
    chk("rst_cen", u_if.o_smem_cen, 1);
    chk("rst_wen", u_if.o_smem_wen, 1);
    chk("rst_addr", u_if.o_smem_addr, 0);
    chk("rst_wdata", u_if.o_smem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single write then single read of the same word
    send_hdr_addr(4'h1, 12'h234, 0);
    send_word(16'hABCD, 0);
    expect_write(12'h234, 16'hABCD, 1'b0);
    send_hdr_addr(4'h0, 12'h234, 0);
    expect_read(16'hABCD);

    // Burst header 4'h5 (three words) starting at 0xFFE
    #1 snap = acc_cnt;
    send_hdr_addr(4'h5, 12'hFFE, 0);
    send_word(16'h1111, 0);
`ifdef SMEM_BRIDGE_BURST_EN
    expect_write(12'hFFE, 16'h1111, 1'b1);
    send_word(16'h2222, 0);
    expect_write(12'hFFF, 16'h2222, 1'b1);
    send_word(16'h3333, 0);
    expect_write(12'h000, 16'h3333, 1'b0);
    #1 chk("burst_access_count", acc_cnt - snap, 3);
`else
    expect_write(12'hFFE, 16'h1111, 1'b0);
    #1 chk("burst_access_count", acc_cnt - snap, 1);
`endif

    // Write frame with three idle cycles before every beat
    send_hdr_addr(4'h1, 12'h234, 3);
    send_word(16'hABCD, 3);
    expect_write(12'h234, 16'hABCD, 1'b0);

    // Abort after two address beats; a beat offered while disabled is refused
    #1 snap = acc_cnt;
    send(4'h0, 0);
    send(4'h4, 0);
    send(4'h3, 0);
    @(negedge clk);
    en = 1'b0;
    u_if.i_ext_valid = 1'b1;
    u_if.i_ext_data  = 4'h2;
    @(negedge clk);
    chk("abort_ready", u_if.o_ext_ready, 0);
    chk("abort_busy", u_if.o_busy, 0);
    @(negedge clk);
    u_if.i_ext_valid = 1'b0;
    en = 1'b1;
    #1 chk("abort_no_access", acc_cnt - snap, 0);
    send_hdr_addr(4'h0, 12'h234, 0);
    expect_read(16'hABCD);

    // Asynchronous reset on the second output beat
    send_hdr_addr(4'h0, 12'h234, 0);
    repeat (3) @(negedge clk);
    chk("ro_beat1_rdata", u_if.o_ext_rdata, 4'hD);
    @(negedge clk);
    chk("ro_beat2_rdata", u_if.o_ext_rdata, 4'hC);
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", u_if.o_ext_rvalid, 0);
    chk("mid_rst_cen", u_if.o_smem_cen, 1);
    chk("mid_rst_busy", u_if.o_busy, 0);
    chk("mid_rst_rdata", u_if.o_ext_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    send_hdr_addr(4'h1, 12'h5A3, 0);
    send_word(16'h1357, 0);
    expect_write(12'h5A3, 16'h1357, 1'b0);
    send_hdr_addr(4'h0, 12'h5A3, 0);
    expect_read(16'h1357);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
